// File: rtl/hd44780_bus_ctrl.sv
// hd44780_bus_ctrl: timed HD44780 bus master.
// Takes one read/write request per handshake and drives the RS/RW/E/DATA waveform,
// returning read bytes (busy flag, address counter, RAM data) as a one-cycle response.
// Optional build macro: HD44780_BUSY_POLL_EN -- poll the busy flag before every request.
module hd44780_bus_ctrl #(
  parameter int T_AS     = 4,
  parameter int T_PW     = 24,
  parameter int T_H      = 2,
  parameter int T_GAP    = 20,
  parameter int CNT_W    = 8,
  parameter int POLL_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_rw,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data_o,
  input  logic [7:0] lcd_data_i,
  output logic       lcd_data_oe,
  output logic       poll_err
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_GAP} state_t;

  // Counter reload values: each phase lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] AS_LD   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_LD   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_LD    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((T_GAP > 0) ? (T_GAP - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, cap, cycle_done;
  logic             req_rs_q, req_rw_q;
  logic [7:0]       req_data_q;
  logic             rs_sel, rw_sel, cyc_rw, active_nxt;
  logic [7:0]       data_sel;
  logic             poll_q, poll_nxt;
  logic             ready_nxt, lcd_e_nxt, lcd_rs_nxt, lcd_rw_nxt, lcd_oe_nxt, rsp_valid_nxt;
  logic [7:0]       lcd_do_nxt, rsp_data_nxt;

  // Phase sequencing: SETUP -> EHIGH -> HOLD -> GAP, each timed by one down-counter.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    cap        = 1'b0;
    cycle_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = S_SETUP;
          cnt_nxt   = AS_LD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt == CNT_ZERO) begin
          state_nxt = S_EHIGH;
          cnt_nxt   = PW_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_EHIGH: begin
        if (cnt == CNT_ZERO) begin
          state_nxt = S_HOLD;
          cnt_nxt   = H_LD;
          cap       = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt == CNT_ZERO) begin
          if (T_GAP == 0) begin
            cycle_done = 1'b1;
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LD;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == CNT_ZERO) begin
          cycle_done = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
    // A finished poll cycle always chains into another bus cycle (poll or the request).
    if (cycle_done) begin
      if (poll_q) begin
        state_nxt = S_SETUP;
        cnt_nxt   = AS_LD;
      end else begin
        state_nxt = S_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    end else begin
      cnt_nxt = cnt_nxt;
    end
  end

`ifdef HD44780_BUSY_POLL_EN
  localparam int             PC_W   = $clog2(POLL_MAX + 1);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(POLL_MAX);

  logic            more_q, more_nxt, err_nxt;
  logic [PC_W-1:0] pcnt, pcnt_nxt;

  // Busy-flag polling: keep polling while BF=1 until the poll budget runs out.
  always_comb begin
    poll_nxt = poll_q;
    more_nxt = more_q;
    pcnt_nxt = pcnt;
    err_nxt  = poll_err;
    if (accept) begin
      poll_nxt = 1'b1;
      more_nxt = 1'b1;
      pcnt_nxt = {PC_W{1'b0}};
    end else if (cap && poll_q) begin
      pcnt_nxt = pcnt + PC_ONE;
      if (lcd_data_i[7] && ((pcnt + PC_ONE) == PC_MAX)) begin
        more_nxt = 1'b0;
        err_nxt  = 1'b1;
      end else begin
        more_nxt = lcd_data_i[7];
      end
    end else if (cycle_done && poll_q) begin
      poll_nxt = more_q;
    end else begin
      poll_nxt = poll_q;
    end
  end

  // Poll bookkeeping registers; poll_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      more_q   <= 1'b0;
      pcnt     <= {PC_W{1'b0}};
      poll_err <= 1'b0;
    end else begin
      more_q   <= more_nxt;
      pcnt     <= pcnt_nxt;
      poll_err <= err_nxt;
    end
  end
`else
  // Without polling every request goes straight onto the bus.
  always_comb begin
    poll_nxt = 1'b0;
  end

  assign poll_err = 1'b0;
`endif

  // Pin values for the next cycle; a poll cycle forces an RS=0 read.
  always_comb begin
    if (accept) begin
      rs_sel   = req_rs;
      rw_sel   = req_rw;
      data_sel = req_data;
    end else begin
      rs_sel   = req_rs_q;
      rw_sel   = req_rw_q;
      data_sel = req_data_q;
    end
    active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_EHIGH) || (state_nxt == S_HOLD);
    cyc_rw     = poll_nxt ? 1'b1 : rw_sel;
    ready_nxt  = (state_nxt == S_IDLE);
    lcd_e_nxt  = (state_nxt == S_EHIGH);
    if (active_nxt) begin
      lcd_rs_nxt = poll_nxt ? 1'b0 : rs_sel;
      lcd_rw_nxt = cyc_rw;
      lcd_oe_nxt = ~cyc_rw;
      lcd_do_nxt = poll_nxt ? lcd_data_o : data_sel;
    end else begin
      lcd_rs_nxt = lcd_rs;
      lcd_rw_nxt = 1'b1;
      lcd_oe_nxt = 1'b0;
      lcd_do_nxt = lcd_data_o;
    end
    if (cap && !poll_q && req_rw_q) begin
      rsp_valid_nxt = 1'b1;
      rsp_data_nxt  = lcd_data_i;
    end else begin
      rsp_valid_nxt = 1'b0;
      rsp_data_nxt  = rsp_data;
    end
  end

  // State, latched request and registered pin/response outputs (E cannot glitch).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= CNT_ZERO;
      poll_q      <= 1'b0;
      req_rs_q    <= 1'b0;
      req_rw_q    <= 1'b0;
      req_data_q  <= 8'h00;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b1;
      lcd_e       <= 1'b0;
      lcd_data_o  <= 8'h00;
      lcd_data_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      poll_q      <= poll_nxt;
      req_rs_q    <= rs_sel;
      req_rw_q    <= rw_sel;
      req_data_q  <= data_sel;
      req_ready   <= ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      lcd_rs      <= lcd_rs_nxt;
      lcd_rw      <= lcd_rw_nxt;
      lcd_e       <= lcd_e_nxt;
      lcd_data_o  <= lcd_do_nxt;
      lcd_data_oe <= lcd_oe_nxt;
    end
  end

endmodule

// File: tb/tb_hd44780_bus_ctrl.sv
// tb_hd44780_bus_ctrl: directed bench for hd44780_bus_ctrl with default timing.
// Cycle 0 is the cycle in which a request is presented with req_ready=1.
module tb_hd44780_bus_ctrl;
`ifdef HD44780_BUSY_POLL_EN
  localparam int PMAX = 4;
`else
  localparam int PMAX = 255;
`endif
  localparam int TR_N = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic       req_rw = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_data_oe, poll_err;
  logic [7:0] lcd_data_o;
  logic [7:0] lcd_data_i = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  logic       tr_e [TR_N];
  logic       tr_rs[TR_N];
  logic       tr_rw[TR_N];
  logic       tr_oe[TR_N];
  logic       tr_rdy[TR_N];
  logic       tr_rv[TR_N];
  logic       tr_err[TR_N];
  logic [7:0] tr_do[TR_N];
  logic [7:0] tr_rd[TR_N];

  hd44780_bus_ctrl #(.T_AS(4), .T_PW(24), .T_H(2), .T_GAP(20), .CNT_W(8), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_rw(req_rw), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data_o(lcd_data_o), .lcd_data_i(lcd_data_i), .lcd_data_oe(lcd_data_oe),
    .poll_err(poll_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record n cycles starting at the current cycle (called just after a posedge).
  // req_valid drops from cycle valid_cycles on; req_data changes to 0x33 at cycle 1;
  // lcd_data_i = dat_val at dat_cycle, else 0x80 before bf_until, else 0x00;
  // rst is pulsed over cycles rst_at..rst_at+1 when rst_at >= 0.
  task automatic capture(input int n, input int valid_cycles, input int dat_cycle,
                         input logic [7:0] dat_val, input int bf_until, input int rst_at);
    for (int i = 0; i < n; i++) begin
      if (i >= valid_cycles) req_valid = 1'b0;
      if (i == 1) req_data = 8'h33;
      if (i == dat_cycle) lcd_data_i = dat_val;
      else if (i < bf_until) lcd_data_i = 8'h80;
      else lcd_data_i = 8'h00;
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 2) rst = 1'b0;
      @(negedge clk);
      tr_e[i] = lcd_e;  tr_rs[i] = lcd_rs; tr_rw[i] = lcd_rw; tr_oe[i] = lcd_data_oe;
      tr_rdy[i] = req_ready; tr_rv[i] = rsp_valid; tr_err[i] = poll_err;
      tr_do[i] = lcd_data_o; tr_rd[i] = rsp_data;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic start(input logic rs, input logic rw, input logic [7:0] d);
    wait_idle();
    req_rs = rs; req_rw = rw; req_data = d; req_valid = 1'b1;
  endtask

  int strobes;
  int first_e[8];
  logic err_before;

  initial begin
    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready", {31'd0, req_ready}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst lcd_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst lcd_rw", {31'd0, lcd_rw}, 32'd1);
    check("rst lcd_e", {31'd0, lcd_e}, 32'd0);
    check("rst data_o", {24'd0, lcd_data_o}, 32'd0);
    check("rst oe", {31'd0, lcd_data_oe}, 32'd0);
    check("rst poll_err", {31'd0, poll_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready after rst", {31'd0, req_ready}, 32'd1);

`ifndef HD44780_BUSY_POLL_EN
    // Single write rs=1 data=0x41; req_data changing at cycle 1 must be ignored.
    start(1'b1, 1'b0, 8'h41);
    capture(56, 1, -1, 8'h00, 0, -1);
    for (int i = 0; i < 56; i++) begin
      check($sformatf("wr e c%0d", i), 32'(tr_e[i]), 32'(i >= 5 && i <= 28));
      check($sformatf("wr ready c%0d", i), 32'(tr_rdy[i]), 32'(i == 0 || i >= 51));
      check($sformatf("wr oe c%0d", i), 32'(tr_oe[i]), 32'(i >= 1 && i <= 30));
      check($sformatf("wr rw c%0d", i), 32'(tr_rw[i]), 32'(!(i >= 1 && i <= 30)));
      check($sformatf("wr rsp_valid c%0d", i), 32'(tr_rv[i]), 32'd0);
      if (i >= 1) check($sformatf("wr rs c%0d", i), 32'(tr_rs[i]), 32'd1);
      if (i >= 1 && i <= 30) check($sformatf("wr data_o c%0d", i), 32'(tr_do[i]), 32'h41);
    end

    // Read rs=0: only cycle 28 carries 0x80 on the bus.
    start(1'b0, 1'b1, 8'h00);
    capture(56, 1, 28, 8'h80, 0, -1);
    for (int i = 0; i < 56; i++) begin
      check($sformatf("rd e c%0d", i), 32'(tr_e[i]), 32'(i >= 5 && i <= 28));
      check($sformatf("rd oe c%0d", i), 32'(tr_oe[i]), 32'd0);
      check($sformatf("rd rw c%0d", i), 32'(tr_rw[i]), 32'd1);
      check($sformatf("rd rsp_valid c%0d", i), 32'(tr_rv[i]), 32'(i == 29));
      check($sformatf("rd rsp_data c%0d", i), 32'(tr_rd[i]), (i >= 29) ? 32'h80 : 32'h00);
      check($sformatf("rd ready c%0d", i), 32'(tr_rdy[i]), 32'(i == 0 || i >= 51));
      if (i >= 1) check($sformatf("rd rs c%0d", i), 32'(tr_rs[i]), 32'd0);
    end

    // Back-to-back writes with req_valid held: second accept at cycle 51 with 0x33.
    start(1'b1, 1'b0, 8'h41);
    capture(90, 52, -1, 8'h00, 0, -1);
    for (int i = 0; i < 90; i++) begin
      check($sformatf("b2b e c%0d", i), 32'(tr_e[i]),
            32'((i >= 5 && i <= 28) || (i >= 56 && i <= 79)));
      check($sformatf("b2b ready c%0d", i), 32'(tr_rdy[i]), 32'(i == 0 || i == 51));
      check($sformatf("b2b rw c%0d", i), 32'(tr_rw[i]),
            32'(!((i >= 1 && i <= 30) || (i >= 52 && i <= 81))));
      if (i >= 1 && i <= 30) check($sformatf("b2b data1 c%0d", i), 32'(tr_do[i]), 32'h41);
      if (i >= 52 && i <= 81) check($sformatf("b2b data2 c%0d", i), 32'(tr_do[i]), 32'h33);
    end
    err_before = 1'b0;
`else
    // BF=1 on the first three polls, 0 on the fourth: 4 poll strobes, then the write.
    for (int t = 0; t < 2; t++) begin
      start(1'b1, 1'b0, 8'h41);
      capture(260, 1, -1, 8'h00, (t == 0) ? 151 : 1000, -1);
      strobes = 0;
      for (int i = 1; i < 260; i++) begin
        if (tr_e[i] && !tr_e[i-1]) begin
          if (strobes < 8) first_e[strobes] = i;
          strobes++;
        end
        check($sformatf("poll%0d rsp_valid c%0d", t, i), 32'(tr_rv[i]), 32'd0);
      end
      check($sformatf("poll%0d strobes", t), 32'(strobes), 32'd5);
      for (int k = 0; k < 5; k++) begin
        check($sformatf("poll%0d strobe%0d start", t, k), 32'(first_e[k]), 32'(5 + 50 * k));
        check($sformatf("poll%0d strobe%0d rw", t, k), 32'(tr_rw[5 + 50 * k]), 32'(k < 4));
        check($sformatf("poll%0d strobe%0d rs", t, k), 32'(tr_rs[5 + 50 * k]), 32'(k == 4));
        check($sformatf("poll%0d strobe%0d oe", t, k), 32'(tr_oe[5 + 50 * k]), 32'(k == 4));
      end
      check($sformatf("poll%0d data_o", t), 32'(tr_do[205]), 32'h41);
      check($sformatf("poll%0d ready c250", t), 32'(tr_rdy[250]), 32'd0);
      check($sformatf("poll%0d ready c251", t), 32'(tr_rdy[251]), 32'd1);
      check($sformatf("poll%0d err c178", t), 32'(tr_err[178]), 32'd0);
      check($sformatf("poll%0d err c179", t), 32'(tr_err[179]), 32'(t == 1));
      check($sformatf("poll%0d err c259", t), 32'(tr_err[259]), 32'(t == 1));
    end
    err_before = 1'b1;
`endif

    // Reset asserted in cycle 10 of a write (E high), held for two cycles.
    start(1'b1, 1'b0, 8'h41);
    capture(20, 1, -1, 8'h00, 0, 10);
    check("rstmid e c10", 32'(tr_e[10]), 32'd1);
    check("rstmid err c9", 32'(tr_err[9]), 32'(err_before));
    for (int i = 11; i < 20; i++) begin
      check($sformatf("rstmid e c%0d", i), 32'(tr_e[i]), 32'd0);
      check($sformatf("rstmid oe c%0d", i), 32'(tr_oe[i]), 32'd0);
      check($sformatf("rstmid rw c%0d", i), 32'(tr_rw[i]), 32'd1);
      check($sformatf("rstmid ready c%0d", i), 32'(tr_rdy[i]), 32'(i >= 13));
      check($sformatf("rstmid rsp_valid c%0d", i), 32'(tr_rv[i]), 32'd0);
      check($sformatf("rstmid err c%0d", i), 32'(tr_err[i]), 32'd0);
    end
    check("rstmid rsp_data c11", 32'(tr_rd[11]), 32'd0);
    check("rstmid data_o c11", 32'(tr_do[11]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
